// File: rtl/uart_tx_cfg.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_cfg
// Description : Buffered UART transmitter with compile-time data width,
//               parity and stop-bit count; queued frames leave back-to-back.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_cfg #(
  parameter int CLOCKS_PER_BAUD = 4,
  parameter int DATA_BITS       = 8,
  parameter int PARITY          = 0,
  parameter int STOP_BITS       = 1,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 write_i,
  input  logic [DATA_BITS-1:0] data_i,
  output logic                 full_o,
  output logic                 busy_o,
  output logic                 tx_o
);

  localparam int c_PTR_W    = $clog2(FIFO_DEPTH);
  localparam int c_CNT_W    = c_PTR_W + 1;
  localparam int c_STOP_LEN = STOP_BITS * CLOCKS_PER_BAUD;
  localparam int c_BAUD_W   = $clog2(c_STOP_LEN);
  localparam int c_BIT_W    = $clog2(DATA_BITS);

  localparam logic [c_PTR_W-1:0]  c_PTR_ONE   = c_PTR_W'(1);
  localparam logic [c_CNT_W-1:0]  c_CNT_ONE   = c_CNT_W'(1);
  localparam logic [c_CNT_W-1:0]  c_CNT_FULL  = c_CNT_W'(FIFO_DEPTH);
  localparam logic [c_BAUD_W-1:0] c_BAUD_ONE  = c_BAUD_W'(1);
  localparam logic [c_BAUD_W-1:0] c_BAUD_BIT  = c_BAUD_W'(CLOCKS_PER_BAUD - 1);
  localparam logic [c_BAUD_W-1:0] c_BAUD_STOP = c_BAUD_W'(c_STOP_LEN - 1);
  localparam logic [c_BIT_W-1:0]  c_BIT_ONE   = c_BIT_W'(1);
  localparam logic [c_BIT_W-1:0]  c_BIT_LAST  = c_BIT_W'(DATA_BITS - 1);

  localparam logic [2:0] c_ST_IDLE   = 3'd0;
  localparam logic [2:0] c_ST_START  = 3'd1;
  localparam logic [2:0] c_ST_DATA   = 3'd2;
  localparam logic [2:0] c_ST_PARITY = 3'd3;
  localparam logic [2:0] c_ST_STOP   = 3'd4;

  if (CLOCKS_PER_BAUD < 2) begin : g_bad_baud
    $error("uart_tx_cfg: CLOCKS_PER_BAUD must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_cfg: DATA_BITS must be in 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_cfg: FIFO_DEPTH must be a power of 2, at least 2");
  end

  logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [c_PTR_W-1:0]   r_wr_ptr;
  logic [c_PTR_W-1:0]   r_rd_ptr;
  logic [c_CNT_W-1:0]   r_count;
  logic [2:0]           r_state;
  logic [c_BAUD_W-1:0]  r_baud_cnt;
  logic [c_BIT_W-1:0]   r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par;
  logic                 r_tx;

  logic                 w_full;
  logic                 w_empty;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_tick;
  logic                 w_par;
  logic [DATA_BITS-1:0] w_rd_data;

  assign w_full    = (r_count == c_CNT_FULL);
  assign w_empty   = (r_count == '0);
  assign w_push    = write_i && !w_full;
  assign w_tick    = (r_baud_cnt == '0);
  // The FSM takes the next word either from IDLE or straight out of the last stop cycle.
  assign w_pop     = !w_empty && ((r_state == c_ST_IDLE) || ((r_state == c_ST_STOP) && w_tick));
  assign w_rd_data = r_mem[r_rd_ptr];
  assign w_par     = (PARITY == 2) ? ^w_rd_data : ~(^w_rd_data);

  assign full_o = w_full;
  assign busy_o = (r_state != c_ST_IDLE) || !w_empty;
  assign tx_o   = r_tx;

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + c_CNT_ONE;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - c_CNT_ONE;
      end
    end
  end

  // r_tx is loaded with the level of the state being entered, so the line is registered.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= c_ST_IDLE;
      r_tx       <= 1'b1;
      r_baud_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_par      <= 1'b0;
    end else if ((r_state != c_ST_IDLE) && !w_tick) begin
      r_baud_cnt <= r_baud_cnt - c_BAUD_ONE;
    end else begin
      case (r_state)
        c_ST_IDLE, c_ST_STOP: begin
          if (w_pop) begin
            r_state    <= c_ST_START;
            r_tx       <= 1'b0;
            r_baud_cnt <= c_BAUD_BIT;
            r_shift    <= w_rd_data;
            r_par      <= w_par;
          end else begin
            r_state <= c_ST_IDLE;
            r_tx    <= 1'b1;
          end
        end
        c_ST_START: begin
          r_state    <= c_ST_DATA;
          r_tx       <= r_shift[0];
          r_bit_cnt  <= c_BIT_LAST;
          r_baud_cnt <= c_BAUD_BIT;
        end
        c_ST_DATA: begin
          if (r_bit_cnt != '0) begin
            r_shift    <= r_shift >> 1;
            r_tx       <= r_shift[1];
            r_bit_cnt  <= r_bit_cnt - c_BIT_ONE;
            r_baud_cnt <= c_BAUD_BIT;
          end else if (PARITY != 0) begin
            r_state    <= c_ST_PARITY;
            r_tx       <= r_par;
            r_baud_cnt <= c_BAUD_BIT;
          end else begin
            r_state    <= c_ST_STOP;
            r_tx       <= 1'b1;
            r_baud_cnt <= c_BAUD_STOP;
          end
        end
        c_ST_PARITY: begin
          r_state    <= c_ST_STOP;
          r_tx       <= 1'b1;
          r_baud_cnt <= c_BAUD_STOP;
        end
        default: begin
          r_state <= c_ST_IDLE;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
